mvu_csr_dispatch: RTL

MVU_CSR_DISPATCH -- requirements
Module: mvu_csr_dispatch

---
 rtl/mvu_csr_dispatch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mvu_csr_dispatch.sv
// CSR write decoder for the MVU array: per-hart config banks and job-start sequencing.
// Each hart has an IDLE/BUSY/DONE controller with sticky error flags and a level irq.
module mvu_csr_dispatch #(
  parameter int          NMVU     = 8,
  parameter int          HID_W    = 3,
  parameter logic [11:0] CSR_BASE = 12'hF20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csr_wr_valid,
  output logic             csr_wr_ready,
  input  logic [HID_W-1:0] csr_wr_hart,
  input  logic [11:0]      csr_wr_addr,
  input  logic [31:0]      csr_wr_data,
  output logic [NMVU-1:0]  mvu_start,
  output logic [15:0]      mvu_wbase,
  output logic [15:0]      mvu_ibase,
  output logic [15:0]      mvu_obase,
  output logic [11:0]      mvu_prec,
  output logic [15:0]      mvu_countdown,
  input  logic [NMVU-1:0]  mvu_done,
  output logic [NMVU-1:0]  mvu_irq,
  output logic [NMVU-1:0]  err_busy,
  output logic [NMVU-1:0]  err_cfg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state_q [NMVU];
  state_t      state_d [NMVU];

  logic [15:0] wbase_r [NMVU];
  logic [15:0] ibase_r [NMVU];
  logic [15:0] obase_r [NMVU];
  logic [11:0] prec_r  [NMVU];
  logic [15:0] cd_r    [NMVU];

  logic            ready_q;
  logic [11:0]     off;
  logic            hit;
  logic [NMVU-1:0] sel;
  logic [NMVU-1:0] cmd_v;
  logic [NMVU-1:0] ack_v;
  logic [NMVU-1:0] start_d;
  logic [NMVU-1:0] irq_d;
  logic [NMVU-1:0] eb_d;
  logic [NMVU-1:0] ec_d;

  assign csr_wr_ready = ready_q;

  // Offset wraps for addresses below the base, so one compare covers both window edges.
  assign off = csr_wr_addr - CSR_BASE;
  assign hit = csr_wr_valid && ready_q && (off < 12'd7) && (int'(csr_wr_hart) < NMVU);

  always_comb begin
    sel   = '0;
    cmd_v = '0;
    ack_v = '0;
    for (int unsigned i = 0; i < NMVU; i++) begin
      sel[i]   = hit && (csr_wr_hart == HID_W'(i));
      cmd_v[i] = sel[i] && (off == 12'd5) && csr_wr_data[0];
      ack_v[i] = sel[i] && (off == 12'd6);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NMVU; i++) begin
      if (!rst_n) begin
        wbase_r[i] <= '0;
        ibase_r[i] <= '0;
        obase_r[i] <= '0;
        prec_r[i]  <= '0;
        cd_r[i]    <= '0;
      end else if (sel[i]) begin
        case (off)
          12'd0:   wbase_r[i] <= csr_wr_data[15:0];
          12'd1:   ibase_r[i] <= csr_wr_data[15:0];
          12'd2:   obase_r[i] <= csr_wr_data[15:0];
          12'd3:   prec_r[i]  <= csr_wr_data[11:0];
          12'd4:   cd_r[i]    <= csr_wr_data[15:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    start_d = '0;
    irq_d   = mvu_irq;
    eb_d    = err_busy;
    ec_d    = err_cfg;
    for (int unsigned i = 0; i < NMVU; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE, S_DONE: begin
          if (cmd_v[i]) begin
            if (cd_r[i] == '0) begin
              ec_d[i] = 1'b1;
            end else begin
              start_d[i] = 1'b1;
              irq_d[i]   = 1'b0;
              state_d[i] = S_BUSY;
            end
          end else if (ack_v[i]) begin
            eb_d[i] = 1'b0;
            ec_d[i] = 1'b0;
            if (state_q[i] == S_DONE) begin
              irq_d[i]   = 1'b0;
              state_d[i] = S_IDLE;
            end
          end
        end
        S_BUSY: begin
          // Acks are ignored here, so a coincident done always wins.
          if (cmd_v[i]) begin
            eb_d[i] = 1'b1;
            if (cd_r[i] == '0) ec_d[i] = 1'b1;
          end
          if (mvu_done[i]) begin
            irq_d[i]   = 1'b1;
            state_d[i] = S_DONE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      mvu_start     <= '0;
      mvu_wbase     <= '0;
      mvu_ibase     <= '0;
      mvu_obase     <= '0;
      mvu_prec      <= '0;
      mvu_countdown <= '0;
      mvu_irq       <= '0;
      err_busy      <= '0;
      err_cfg       <= '0;
      for (int unsigned i = 0; i < NMVU; i++) state_q[i] <= S_IDLE;
    end else begin
      ready_q   <= 1'b1;
      mvu_start <= start_d;
      mvu_irq   <= irq_d;
      err_busy  <= eb_d;
      err_cfg   <= ec_d;
      for (int unsigned i = 0; i < NMVU; i++) begin
        state_q[i] <= state_d[i];
        if (start_d[i]) begin
          mvu_wbase     <= wbase_r[i];
          mvu_ibase     <= ibase_r[i];
          mvu_obase     <= obase_r[i];
          mvu_prec      <= prec_r[i];
          mvu_countdown <= cd_r[i];
        end
      end
    end
  end

endmodule
